xor_rr_arbiter: RTL and testbench

- Shares one registered XOR compute unit among NREQ requesters. Arbitration is round-robin.
- Each requester presents operands a/b with a valid/ready handshake. The block returns y = a ^ b, tagged with the requester index, on a single response channel.
- It sits between multiple gate-level test/stimulus sources and the shared XOR datapath. It sequences access and buffers exactly one result.

---
 rtl/xor_rr_arbiter.sv | 103 ++++++++++
 tb/tb_xor_rr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xor_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one registered XOR unit (y = a ^ b, tagged with requester id) among NREQ requesters.
// Latency: operands taken at edge N appear on rsp_* with rsp_valid=1 right after edge N; one result per cycle back-to-back.
// Backpressure: single result register; no grant while a held result is not being consumed (rsp_ready=0).
// Optional: define XOR_ARB_PARITY_EN to add rsp_par, the registered even parity of the result.
module xor_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [IDW-1:0]        rsp_id
`ifdef XOR_ARB_PARITY_EN
  ,
  output logic                  rsp_par
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_y;
  logic [IDW-1:0]   r_id;

  logic             w_accept;
  logic             w_found;
  logic             w_grant;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_y;

  // The result slot can take a new operand pair when empty or when it is being drained this cycle.
  assign w_accept = (r_state == ST_IDLE) || rsp_ready;

  // Search requesters starting at the round-robin pointer and wrapping; the first valid one wins.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_gidx  = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_gidx  = IDW'(j);
      end
    end
  end

  // Gating with rst_n keeps req_ready low for the whole time reset is asserted.
  assign w_grant   = rst_n && w_accept && w_found;
  assign req_ready = w_grant ? (NREQ'(1) << w_gidx) : '0;

  assign w_y       = req_a[int'(w_gidx)*WIDTH +: WIDTH] ^ req_b[int'(w_gidx)*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

  // Result register and FSM: load on grant, drop to IDLE when drained without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_y     <= '0;
      r_id    <= '0;
    end else if (w_grant) begin
      r_state <= ST_HOLD;
      r_ptr   <= w_ptr_nxt;
      r_y     <= w_y;
      r_id    <= w_gidx;
    end else if ((r_state == ST_HOLD) && rsp_ready) begin
      r_state <= ST_IDLE;
    end
  end

  assign rsp_valid = (r_state == ST_HOLD);
  assign rsp_y     = r_y;
  assign rsp_id    = r_id;

`ifdef XOR_ARB_PARITY_EN
  logic r_par;

  // Parity follows the same load/hold rules as the result itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_grant) begin
      r_par <= ^w_y;
    end
  end

  assign rsp_par = r_par;
`endif

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// Directed bench for xor_rr_arbiter (NREQ=4, WIDTH=8) with a result scoreboard and a small reference model.
module tb_xor_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
`ifdef XOR_ARB_PARITY_EN
  logic        rsp_par;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] id;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  logic m_hold = 1'b0;
  int   last_g = -1;
  logic [7:0] saved_y;

  xor_rr_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
`ifdef XOR_ARB_PARITY_EN
    ,
    .rsp_par   (rsp_par)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven after a negedge; check, update model, advance to next negedge.
  task automatic step();
    logic       acc;
    int         g;
    logic [3:0] er;
    exp_t       e;
    #1;
    acc = !m_hold || rsp_ready;
    g   = -1;
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_hold));
    if (m_hold && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_pop: observed empty scoreboard expected a pending result");
      end else begin
        e = sb.pop_front();
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
`ifdef XOR_ARB_PARITY_EN
        chk("rsp_par", 32'(rsp_par), 32'(e.par));
`endif
      end
    end
    if (g >= 0) begin
      e.y   = req_a[g*8 +: 8] ^ req_b[g*8 +: 8];
      e.id  = 2'(g);
      e.par = ^e.y;
      sb.push_back(e);
      m_ptr  = (g + 1) % 4;
      m_hold = 1'b1;
    end else if (rsp_ready) begin
      m_hold = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
    if (g >= 0) begin
      req_a[g*8 +: 8] = 8'($urandom);
      req_b[g*8 +: 8] = 8'($urandom);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = $urandom;
    req_b     = $urandom;

    // Reset with every requester asking.
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_y", 32'(rsp_y), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all requesting, consumer always ready.
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fair_gnt", 32'(last_g), 32'(i % 4));
    end
    req_valid = 4'b0000;
    step();

    // Single operations from requester 0.
    req_valid = 4'b0001;
    req_a[7:0] = 8'hA5;
    req_b[7:0] = 8'h0F;
    step();
    chk("op1_gnt", 32'(last_g), 32'h0);
    chk("op1_valid", 32'(rsp_valid), 32'h1);
    chk("op1_y", 32'(rsp_y), 32'hAA);
    chk("op1_id", 32'(rsp_id), 32'h0);
    req_a[7:0] = 8'h0C;
    req_b[7:0] = 8'h0A;
    step();
    chk("op2_gnt", 32'(last_g), 32'h0);
    chk("op2_y", 32'(rsp_y), 32'h06);
    chk("op2_id", 32'(rsp_id), 32'h0);

    // Backpressure: hold the result for five cycles, then release.
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    saved_y   = rsp_y;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_y_stable", 32'(rsp_y), 32'(saved_y));
      chk("bp_id_stable", 32'(rsp_id), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_gnt", 32'(last_g), 32'h1);

    // Pointer skip and wrap.
    req_valid = 4'b0100;
    step();
    chk("wrap_gnt2", 32'(last_g), 32'h2);
    req_valid = 4'b1010;
    step();
    chk("wrap_gnt3", 32'(last_g), 32'h3);
    step();
    chk("wrap_gnt1", 32'(last_g), 32'h1);

    // Reset mid-operation: result held, pointer at 2.
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_y", 32'(rsp_y), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    sb.delete();
    m_hold = 1'b0;
    m_ptr  = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    step();
    chk("post_rst_gnt", 32'(last_g), 32'h1);
    req_valid = 4'b0000;
    step();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
